// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the multi-channel clock-enable divider.
// Optional phase-align input is enabled with `define CLKDIV_SYNC_EN.
package clkdiv_pkg;

    localparam int DIV_STALL     = 0;
    localparam int WIDTH_DEFAULT = 24;

    typedef logic [WIDTH_DEFAULT-1:0] div_t;

    // Channel-select width; a single channel still gets a 1-bit select.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/clkdiv_if.sv
// Control/status bundle for clkdiv_multi; sync_i exists only with `define CLKDIV_SYNC_EN.
interface clkdiv_if #(
    parameter int NCH   = 4,
    parameter int WIDTH = 24
);
    localparam int CHW = clkdiv_pkg::ch_idx_w(NCH);

    logic [NCH-1:0]   en_i;
    logic             load_i;
    logic [CHW-1:0]   load_ch_i;
    logic [WIDTH-1:0] load_div_i;
    logic [NCH-1:0]   tick_o;
    logic [NCH-1:0]   slowclk_o;
    logic [NCH-1:0]   pending_o;
`ifdef CLKDIV_SYNC_EN
    logic             sync_i;

    modport master (
        output en_i, load_i, load_ch_i, load_div_i, sync_i,
        input  tick_o, slowclk_o, pending_o
    );
    modport slave (
        input  en_i, load_i, load_ch_i, load_div_i, sync_i,
        output tick_o, slowclk_o, pending_o
    );
`else
    modport master (
        output en_i, load_i, load_ch_i, load_div_i,
        input  tick_o, slowclk_o, pending_o
    );
    modport slave (
        input  en_i, load_i, load_ch_i, load_div_i,
        output tick_o, slowclk_o, pending_o
    );
`endif

endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: counter, active/shadow divisor, tick, slow clock, pending flag.
// With `define CLKDIV_SYNC_EN a sync input phase-aligns the channel.
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int          WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = 25000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
`ifdef CLKDIV_SYNC_EN
    input  logic             sync,
`endif
    input  logic             load,
    input  logic [WIDTH-1:0] load_div,
    output logic             tick,
    output logic             slowclk,
    output logic             pending
);

    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] div;
    logic [WIDTH-1:0] shadow;
    logic             stalled;
    logic             run;
    logic             term;

    always_comb begin
        stalled = (div == WIDTH'(DIV_STALL));
        run     = en && !stalled;
        term    = run && (cnt == div - WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            div     <= WIDTH'(DEFAULT_DIV);
            shadow  <= '0;
            pending <= 1'b0;
            tick    <= 1'b0;
            slowclk <= 1'b0;
        end
`ifdef CLKDIV_SYNC_EN
        else if (sync) begin
            cnt     <= '0;
            slowclk <= 1'b0;
            tick    <= 1'b0;
            pending <= 1'b0;
            if (load)
                div <= load_div;
            else if (pending)
                div <= shadow;
        end
`endif
        else begin
            tick <= term;
            if (term) begin
                cnt     <= '0;
                slowclk <= ~slowclk;
            end else if (run) begin
                cnt <= cnt + WIDTH'(1);
            end

            // Idle/stalled channels and terminal edges take a new divisor at once;
            // a running channel parks it in the shadow until its period ends.
            if (load) begin
                if (!run || term) begin
                    div     <= load_div;
                    pending <= 1'b0;
                    if (!run)
                        cnt <= '0;
                end else begin
                    shadow  <= load_div;
                    pending <= 1'b1;
                end
            end else if (pending && (term || !en)) begin
                div     <= shadow;
                pending <= 1'b0;
                if (!en)
                    cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/clkdiv_multi.sv
// N-channel programmable clock-enable generator with per-channel runtime divisors.
// `define CLKDIV_SYNC_EN adds bus.sync_i for phase-aligning all channels.
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int          NCH         = 4,
    parameter int          WIDTH       = 24,
    parameter int unsigned DEFAULT_DIV = 25000
) (
    input logic     clk,
    input logic     rst,
    clkdiv_if.slave bus
);

    localparam int CHW = ch_idx_w(NCH);

    logic [NCH-1:0] load_str;

    // Out-of-range channel numbers match no index and are dropped.
    always_comb begin
        load_str = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (bus.load_i && (bus.load_ch_i == CHW'(i)))
                load_str[i] = 1'b1;
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clkdiv_chan #(
            .WIDTH       (WIDTH),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en_i[g]),
`ifdef CLKDIV_SYNC_EN
            .sync     (bus.sync_i),
`endif
            .load     (load_str[g]),
            .load_div (bus.load_div_i),
            .tick     (bus.tick_o[g]),
            .slowclk  (bus.slowclk_o[g]),
            .pending  (bus.pending_o[g])
        );
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
- N-channel programmable clock-enable generator; successor to the single fixed-divisor divider.
- Each channel has a runtime-loadable divisor and emits a one-cycle tick plus a 50%-duty toggled slow clock.
- Sits beside the system clock and feeds timers, display refresh, debounce and reaction-time counters.
- Downstream logic uses tick_o as a clock enable; slowclk_o exists for legacy users.

Parameters:
- NCH, 4, number of independent channels (1..16).
- WIDTH, 24, divisor/counter width in bits.
- DEFAULT_DIV, 25000, active divisor of every channel after reset; must be < 2^WIDTH.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en_i  in  NCH  per-channel run enable.
- load_i  in  1  divisor write strobe, single cycle.
- load_ch_i  in  $clog2(NCH) (min 1)  channel addressed by load_i.
- load_div_i  in  WIDTH  new divisor value.
- tick_o  out  NCH  one-cycle pulse per period, registered.
- slowclk_o  out  NCH  toggles on every tick.
- pending_o  out  NCH  shadow divisor waiting to be applied.

Behaviour:
- Reset (rst=1 at a clk edge): cnt=0, active div=DEFAULT_DIV, shadow=0, pending_o=0, tick_o=0, slowclk_o=0, for all channels. Reset overrides every other input, including a load in the same cycle.
- Per channel, counting (en=1, div>=1):
  - cnt counts 0..div-1.
  - At the edge where cnt==div-1: cnt<=0, tick<=1 for exactly one cycle, slowclk<=~slowclk.
  - Tick period = div cycles; slowclk period = 2*div cycles.
  - div=1: tick held high continuously, slowclk toggles every cycle.
- First tick after reset with en held high occurs at the div-th rising edge.
- en=0: cnt and slowclk hold (pause, not clear); tick=0. Counting resumes from the held cnt when en returns to 1.
- div=0: channel stalled; cnt held at 0, tick=0, slowclk holds.
- Load handling (load_i=1, channel c=load_ch_i):
  - Immediate apply: if channel c has en=0, or active div=0, then div<=load_div_i, cnt<=0, pending stays 0. Change is visible next cycle.
  - Deferred apply (otherwise): shadow<=load_div_i, pending<=1. At the next terminal edge (cnt==div-1): div<=shadow, pending<=0.
  - Load in the same cycle as a terminal edge: the new value becomes active immediately for the following period; pending stays 0.
  - Second load while pending: overwrites shadow; last write wins.
  - load_ch_i >= NCH: ignored.
- If a pending channel is disabled, the shadow is applied on the next cycle with en=0, and cnt<=0.
- Arithmetic: unsigned, WIDTH bits; cnt never exceeds div-1, so there is no wrap beyond the terminal.
- Latency: load to active divisor is 1 cycle (immediate) or until the current period ends (deferred).

Optional Feature:
- Macro: CLKDIV_SYNC_EN.
- Defined: adds input sync_i (1 bit).
  - sync_i=1 clears cnt to 0 and slowclk to 0 on all channels in the same cycle and applies any pending shadows.
  - tick=0 in that cycle.
  - Phase-aligns all channels to a common start.
  - rst takes priority over sync_i.
- Undefined: port absent; channels are phase-independent.

Decomposition:
- Package clkdiv_pkg holds:
  - channel index width helper function;
  - constant DIV_STALL=0;
  - typedef div_t (logic [WIDTH-1:0] via parameterised typedef pattern).
- Sub-module clkdiv_chan: one channel (counter, active/shadow registers, tick, slowclk, pending).
- clkdiv_multi instantiates NCH clkdiv_chan via generate and decodes load_ch_i into per-channel load strobes.

Test Plan:
- Reset, then en=4'b0001, DEFAULT_DIV overridden to 5 -> tick_o[0] high on cycles 5, 10, 15 after reset release; slowclk_o[0] period 10; other channels silent.
- Channel 1 running div=8, load 3 at cnt=2 -> pending_o[1]=1 until the cnt=7 edge; afterwards ticks every 3 cycles; pending_o[1] returns to 0.
- Load div=0 to channel 2 while running -> tick stops after the current period; cnt stays 0. Then load 4 -> immediate, first tick 4 cycles later.
- Channel 0 div=6, en dropped at cnt=3 for 10 cycles -> no ticks during the pause; next tick exactly 3 cycles after en returns.
- rst asserted mid-period together with load_i -> all outputs 0 next cycle; divisors back to DEFAULT_DIV; load discarded.
- (CLKDIV_SYNC_EN) channels at div=4 and 6 out of phase, sync_i pulse -> both tick on the 4th and 6th cycle after the pulse respectively; both slowclk_o=0 right after the pulse.
